// File: rtl/parity_chk_gen_multi_if.sv
// Bus bundle for parity_chk_gen_multi: per-channel beats, parity in/out and error status.
// master drives beats and controls; slave is the parity block.
interface parity_chk_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int PAR_W  = 8,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]        CH_VALID;
    logic [NUM_CH*DATA_W-1:0] CH_DATA;
    logic [NUM_CH*PAR_W-1:0]  CH_PAR_IN;
    logic [NUM_CH*PAR_W-1:0]  CH_PAR_OUT;
    logic [NUM_CH-1:0]        CH_PAR_VLD;
    logic                     ENERR;
    logic [NUM_CH-1:0]        FIERR;
    logic                     ERR_CLR;
    logic [NUM_CH-1:0]        ERR_PULSE;
    logic [NUM_CH-1:0]        ERR_STICKY;
    logic                     ERR_B;
    logic [CNT_W-1:0]         ERR_CNT;
    logic                     FIRST_ERR_VLD;
    logic [3:0]               FIRST_ERR_CH;

    modport master (
        output CH_VALID, CH_DATA, CH_PAR_IN, ENERR, FIERR, ERR_CLR,
        input  CH_PAR_OUT, CH_PAR_VLD, ERR_PULSE, ERR_STICKY, ERR_B, ERR_CNT,
               FIRST_ERR_VLD, FIRST_ERR_CH
    );
    modport slave (
        input  CH_VALID, CH_DATA, CH_PAR_IN, ENERR, FIERR, ERR_CLR,
        output CH_PAR_OUT, CH_PAR_VLD, ERR_PULSE, ERR_STICKY, ERR_B, ERR_CNT,
               FIRST_ERR_VLD, FIRST_ERR_CH
    );
endinterface

// File: rtl/parity_chk_gen_multi.sv
// Multi-channel group parity generator/checker with fault injection and shared error status.
// Each channel is one parity_chk_gen_lane; status aggregation lives in the top.
module parity_chk_gen_lane #(
    parameter int DATA_W = 64,
    parameter int GRP_W  = 8,
    parameter int PAR_W  = DATA_W / GRP_W,
    parameter bit ODD    = 1'b0,
    parameter bit GEN    = 1'b0
) (
    input  logic              ACLK,
    input  logic              RESETN_ACLK,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  par_in,
    input  logic              enerr,
    input  logic              fierr,
    output logic [PAR_W-1:0]  par_out,
    output logic              par_vld,
    output logic              err_pulse
);
    logic             fierr_q, arm, inj;
    logic [PAR_W-1:0] p;

    // An armed injection is consumed by the next beat even when reporting is disabled.
    assign inj = arm & valid;

    always_comb begin
        p = '0;
        for (int g = 0; g < PAR_W; g++)
            p[g] = (^data[g*GRP_W +: GRP_W]) ^ ODD;
        p[0] = p[0] ^ inj;
    end

    always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
        if (!RESETN_ACLK) begin
            fierr_q   <= 1'b0;
            arm       <= 1'b0;
            par_out   <= '0;
            par_vld   <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            fierr_q <= fierr;
            if (inj)
                arm <= 1'b0;
            else if (fierr && !fierr_q)
                arm <= 1'b1;
            if (GEN && valid)
                par_out <= p;
            par_vld   <= GEN && valid;
            err_pulse <= valid && enerr && (GEN ? inj : (|(p ^ par_in)));
        end
    end
endmodule

module parity_chk_gen_multi #(
    parameter int               NUM_CH = 4,
    parameter int               DATA_W = 64,
    parameter int               GRP_W  = 8,
    parameter bit               ODD    = 1'b0,
    parameter logic [NUM_CH-1:0] CH_GEN = '0,
    parameter int               CNT_W  = 8
) (
    input logic                   ACLK,
    input logic                   RESETN_ACLK,
    parity_chk_gen_multi_if.slave bus
);
    localparam int               PAR_W   = DATA_W / GRP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0][PAR_W-1:0] par_out;
    logic [NUM_CH-1:0]            par_vld, err_pulse, sticky;
    logic [CNT_W-1:0]             cnt;
    logic                         first_vld, any_err;
    logic [3:0]                   first_ch, first_idx;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        parity_chk_gen_lane #(
            .DATA_W(DATA_W), .GRP_W(GRP_W), .PAR_W(PAR_W), .ODD(ODD), .GEN(CH_GEN[c])
        ) u_lane (
            .ACLK       (ACLK),
            .RESETN_ACLK(RESETN_ACLK),
            .valid      (bus.CH_VALID[c]),
            .data       (bus.CH_DATA[c*DATA_W +: DATA_W]),
            .par_in     (bus.CH_PAR_IN[c*PAR_W +: PAR_W]),
            .enerr      (bus.ENERR),
            .fierr      (bus.FIERR[c]),
            .par_out    (par_out[c]),
            .par_vld    (par_vld[c]),
            .err_pulse  (err_pulse[c])
        );
    end

    assign any_err = |err_pulse;

    always_comb begin
        first_idx = '0;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (err_pulse[c]) first_idx = 4'(c);
    end

    // A pulse landing in the same cycle as ERR_CLR survives the clear.
    always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
        if (!RESETN_ACLK) begin
            sticky    <= '0;
            cnt       <= '0;
            first_vld <= 1'b0;
            first_ch  <= '0;
        end else begin
            sticky <= (bus.ERR_CLR ? '0 : sticky) | err_pulse;
            if (bus.ERR_CLR)
                cnt <= any_err ? CNT_W'(1) : '0;
            else if (any_err && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (bus.ERR_CLR) begin
                first_vld <= any_err;
                first_ch  <= any_err ? first_idx : 4'd0;
            end else if (!first_vld && any_err) begin
                first_vld <= 1'b1;
                first_ch  <= first_idx;
            end
        end
    end

    assign bus.CH_PAR_OUT    = par_out;
    assign bus.CH_PAR_VLD    = par_vld;
    assign bus.ERR_PULSE     = err_pulse;
    assign bus.ERR_STICKY    = sticky;
    assign bus.ERR_B         = ~|sticky;
    assign bus.ERR_CNT       = cnt;
    assign bus.FIRST_ERR_VLD = first_vld;
    assign bus.FIRST_ERR_CH  = first_ch;
endmodule

// File: tb/tb_parity_chk_gen_multi.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops on DUT output.
// dut0: 4 ch, even parity, ch0 generate, 2-bit counter; dut1: 2 ch, odd parity, ch1 generate.
module tb_parity_chk_gen_multi;
    logic ACLK = 1'b0;
    logic RESETN_ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    parity_chk_gen_multi_if #(.NUM_CH(4), .DATA_W(64), .PAR_W(8), .CNT_W(2)) b0 ();
    parity_chk_gen_multi_if #(.NUM_CH(2), .DATA_W(64), .PAR_W(8), .CNT_W(8)) b1 ();

    parity_chk_gen_multi #(.NUM_CH(4), .DATA_W(64), .GRP_W(8), .ODD(1'b0),
                           .CH_GEN(4'b0001), .CNT_W(2))
        u_dut0 (.ACLK(ACLK), .RESETN_ACLK(RESETN_ACLK), .bus(b0));
    parity_chk_gen_multi #(.NUM_CH(2), .DATA_W(64), .GRP_W(8), .ODD(1'b1),
                           .CH_GEN(2'b10), .CNT_W(8))
        u_dut1 (.ACLK(ACLK), .RESETN_ACLK(RESETN_ACLK), .bus(b1));

    typedef struct { int cyc; logic [3:0] pvld; logic [31:0] pout; logic [3:0] pulse; } ev_t;
    typedef struct { int cyc; logic [3:0] st; logic [7:0] cnt; logic fv; logic [3:0] fch; } st_t;

    ev_t qo0[$], qo1[$];
    st_t qs0[$], qs1[$];
    int  cyc = 0, n_vec = 0, n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endfunction

    function automatic int osz(input int d); return (d == 0) ? qo0.size() : qo1.size(); endfunction
    function automatic ev_t ofront(input int d); return (d == 0) ? qo0[0] : qo1[0]; endfunction
    function automatic void opop(input int d);
        if (d == 0) qo0.delete(0); else qo1.delete(0);
    endfunction
    function automatic int ssz(input int d); return (d == 0) ? qs0.size() : qs1.size(); endfunction
    function automatic st_t sfront(input int d); return (d == 0) ? qs0[0] : qs1[0]; endfunction
    function automatic void spop(input int d);
        if (d == 0) qs0.delete(0); else qs1.delete(0);
    endfunction

    // Expected beat response lands one sample after the drive cycle.
    task automatic exp_o(input int d, input logic [3:0] v, input logic [31:0] po, input logic [3:0] pu);
        ev_t e;
        e.cyc = cyc + 1; e.pvld = v; e.pout = po; e.pulse = pu;
        if (d == 0) qo0.push_back(e); else qo1.push_back(e);
    endtask

    task automatic exp_s(input int d, input int dly, input logic [3:0] st, input logic [7:0] cnt,
                         input logic fv, input logic [3:0] fch);
        st_t e;
        e.cyc = cyc + dly; e.st = st; e.cnt = cnt; e.fv = fv; e.fch = fch;
        if (d == 0) qs0.push_back(e); else qs1.push_back(e);
    endtask

    function automatic void mon_o(input int d, input logic [3:0] v, input logic [31:0] po,
                                  input logic [3:0] pu);
        ev_t e;
        while (osz(d) > 0) begin
            e = ofront(d);
            if (e.cyc >= cyc) break;
            n_vec++; n_err++;
            $display("FAIL dut%0d missing output: pulse %0h pvld %0h required at cyc %0d",
                     d, e.pulse, e.pvld, e.cyc);
            opop(d);
        end
        if (v != 0 || pu != 0) begin
            if (osz(d) > 0 && ofront(d).cyc == cyc) begin
                e = ofront(d);
                opop(d);
                chk($sformatf("dut%0d par_vld", d), 32'(v), 32'(e.pvld));
                chk($sformatf("dut%0d par_out", d), po, e.pout);
                chk($sformatf("dut%0d err_pulse", d), 32'(pu), 32'(e.pulse));
            end else begin
                n_vec++; n_err++;
                $display("FAIL dut%0d unexpected output @cyc %0d: pvld %0h pulse %0h, required none",
                         d, cyc, v, pu);
            end
        end
    endfunction

    function automatic void mon_s(input int d, input logic [3:0] st, input logic errb,
                                  input logic [7:0] cnt, input logic fv, input logic [3:0] fch);
        st_t e;
        while (ssz(d) > 0) begin
            e = sfront(d);
            if (e.cyc > cyc) break;
            spop(d);
            chk($sformatf("dut%0d err_sticky", d), 32'(st), 32'(e.st));
            chk($sformatf("dut%0d err_b", d), 32'(errb), 32'(e.st == 4'd0));
            chk($sformatf("dut%0d err_cnt", d), 32'(cnt), 32'(e.cnt));
            chk($sformatf("dut%0d first_err_vld", d), 32'(fv), 32'(e.fv));
            chk($sformatf("dut%0d first_err_ch", d), 32'(fch), 32'(e.fch));
        end
    endfunction

    always @(posedge ACLK) begin
        #1;
        cyc++;
        if (RESETN_ACLK) begin
            mon_o(0, b0.CH_PAR_VLD, b0.CH_PAR_OUT, b0.ERR_PULSE);
            mon_o(1, {2'b0, b1.CH_PAR_VLD}, {16'b0, b1.CH_PAR_OUT}, {2'b0, b1.ERR_PULSE});
            mon_s(0, b0.ERR_STICKY, b0.ERR_B, {6'b0, b0.ERR_CNT}, b0.FIRST_ERR_VLD, b0.FIRST_ERR_CH);
            mon_s(1, {2'b0, b1.ERR_STICKY}, b1.ERR_B, b1.ERR_CNT, b1.FIRST_ERR_VLD, b1.FIRST_ERR_CH);
        end
    end

    task automatic nxt();
        @(negedge ACLK);
        b0.CH_VALID = '0; b1.CH_VALID = '0;
        b0.ERR_CLR  = 1'b0; b1.ERR_CLR = 1'b0;
    endtask

    initial begin
        b0.CH_VALID = '0; b0.CH_DATA = '0; b0.CH_PAR_IN = '0;
        b0.ENERR = 1'b1; b0.FIERR = '0; b0.ERR_CLR = 1'b0;
        b1.CH_VALID = '0; b1.CH_DATA = '0; b1.CH_PAR_IN = '0;
        b1.ENERR = 1'b1; b1.FIERR = '0; b1.ERR_CLR = 1'b0;
        repeat (2) @(negedge ACLK);
        RESETN_ACLK = 1'b1;
        exp_s(0, 1, 4'h0, 8'd0, 1'b0, 4'd0);
        exp_s(1, 1, 4'h0, 8'd0, 1'b0, 4'd0);

        // generate: 0x0103 -> byte0 even (0), byte1 odd (1) -> 8'h02; odd parity -> 8'hFD
        nxt();
        b0.CH_VALID = 4'b0001; b0.CH_DATA[0 +: 64] = 64'h0103;
        b1.CH_VALID = 2'b10;   b1.CH_DATA[64 +: 64] = 64'h0103;
        exp_o(0, 4'b0001, 32'h0000_0002, 4'b0000);
        exp_o(1, 4'b0010, 32'h0000_FD00, 4'b0000);
        nxt();
        b0.CH_DATA[0 +: 64] = 64'hFFFF_0000_0000_0001;   // not a beat: CH_PAR_OUT must hold

        // check ch1: byte0 0xFF has even parity, supplied 1 -> mismatch
        nxt();
        b0.CH_VALID = 4'b0010; b0.CH_DATA[64 +: 64] = 64'hFF; b0.CH_PAR_IN[8 +: 8] = 8'h01;
        exp_o(0, 4'b0000, 32'h0000_0002, 4'b0010);
        exp_s(0, 2, 4'b0010, 8'd1, 1'b1, 4'd1);
        nxt(); nxt();
        nxt(); b0.ERR_CLR = 1'b1;
        exp_s(0, 1, 4'h0, 8'd0, 1'b0, 4'd0);

        // ch2 and ch3 fail in the same beat -> one count, first = 2
        nxt();
        b0.CH_VALID = 4'b1100;
        b0.CH_DATA[128 +: 64] = 64'h1; b0.CH_PAR_IN[16 +: 8] = 8'h00;
        b0.CH_DATA[192 +: 64] = 64'h0; b0.CH_PAR_IN[24 +: 8] = 8'h80;
        exp_o(0, 4'b0000, 32'h0000_0002, 4'b1100);
        exp_s(0, 2, 4'b1100, 8'd1, 1'b1, 4'd2);
        nxt();
        nxt(); b0.CH_VALID = 4'b0010;
        exp_o(0, 4'b0000, 32'h0000_0002, 4'b0010);
        exp_s(0, 2, 4'b1110, 8'd2, 1'b1, 4'd2);
        nxt();
        nxt(); b0.ERR_CLR = 1'b1;
        exp_s(0, 1, 4'h0, 8'd0, 1'b0, 4'd0);

        // five back-to-back error beats, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            nxt(); b0.CH_VALID = 4'b0010;
            exp_o(0, 4'b0000, 32'h0000_0002, 4'b0010);
            exp_s(0, 2, 4'b0010, (i < 2) ? 8'(i + 1) : 8'd3, 1'b1, 4'd1);
        end
        // error pulse coincident with ERR_CLR: counter loads 1, sticky stays
        nxt(); b0.CH_VALID = 4'b0010;
        exp_o(0, 4'b0000, 32'h0000_0002, 4'b0010);
        nxt(); b0.ERR_CLR = 1'b1;
        exp_s(0, 1, 4'b0010, 8'd1, 1'b1, 4'd1);
        nxt(); nxt();

        // injection on generate ch0: bit0 flipped once, pulse raised, first stays 1
        nxt(); b0.FIERR[0] = 1'b1;
        nxt(); b0.CH_VALID = 4'b0001; b0.CH_DATA[0 +: 64] = 64'h0103;
        exp_o(0, 4'b0001, 32'h0000_0003, 4'b0001);
        exp_s(0, 2, 4'b0011, 8'd2, 1'b1, 4'd1);
        nxt(); b0.CH_VALID = 4'b0001;
        exp_o(0, 4'b0001, 32'h0000_0002, 4'b0000);
        nxt(); b0.FIERR[0] = 1'b0;

        // injection on odd-parity check ch0: beat on the edge cycle is clean, next one fails
        b1.CH_DATA[0 +: 64] = 64'h0; b1.CH_PAR_IN[0 +: 8] = 8'hFF;
        nxt(); b1.FIERR[0] = 1'b1; b1.CH_VALID = 2'b01;
        nxt(); b1.CH_VALID = 2'b01;
        exp_o(1, 4'b0000, 32'h0000_FD00, 4'b0001);
        exp_s(1, 2, 4'b0001, 8'd1, 1'b1, 4'd0);
        nxt(); b1.CH_VALID = 2'b01;
        nxt(); b1.CH_VALID = 2'b01;
        // ENERR=0: armed injection is consumed silently
        nxt(); b1.FIERR[0] = 1'b0; b1.ENERR = 1'b0;
        nxt(); b1.FIERR[0] = 1'b1;
        nxt(); b1.CH_VALID = 2'b01;
        nxt(); b1.CH_VALID = 2'b01; b1.ENERR = 1'b1;
        exp_s(1, 2, 4'b0001, 8'd1, 1'b1, 4'd0);
        nxt(); b1.CH_VALID = 2'b01; b1.ENERR = 1'b0; b1.CH_PAR_IN[0 +: 8] = 8'h00;
        nxt(); b1.ENERR = 1'b1; b1.CH_PAR_IN[0 +: 8] = 8'hFF;
        exp_s(1, 2, 4'b0001, 8'd1, 1'b1, 4'd0);
        nxt(); nxt(); nxt();

        // reset mid-traffic with a pending arm on dut0 ch0
        nxt(); b0.FIERR[0] = 1'b1;
        nxt(); b0.CH_VALID = 4'b0001; b0.CH_DATA[0 +: 64] = 64'hFF00; b1.CH_VALID = 2'b10;
        #2 RESETN_ACLK = 1'b0;
        #1;
        chk("rst dut0 par_out", b0.CH_PAR_OUT, 32'h0);
        chk("rst dut0 par_vld", 32'(b0.CH_PAR_VLD), 32'h0);
        chk("rst dut0 err_sticky", 32'(b0.ERR_STICKY), 32'h0);
        chk("rst dut0 err_b", 32'(b0.ERR_B), 32'h1);
        chk("rst dut0 err_cnt", 32'(b0.ERR_CNT), 32'h0);
        chk("rst dut0 first_vld", 32'(b0.FIRST_ERR_VLD), 32'h0);
        chk("rst dut1 par_out", 32'(b1.CH_PAR_OUT), 32'h0);
        chk("rst dut1 err_sticky", 32'(b1.ERR_STICKY), 32'h0);
        chk("rst dut1 err_b", 32'(b1.ERR_B), 32'h1);
        chk("rst dut1 err_cnt", 32'(b1.ERR_CNT), 32'h0);
        b0.FIERR[0] = 1'b0; b0.CH_VALID = '0; b1.CH_VALID = '0;
        repeat (2) @(negedge ACLK);
        RESETN_ACLK = 1'b1;
        // the pre-reset arm must be gone: clean parity, no pulse
        b0.CH_VALID = 4'b0001; b0.CH_DATA[0 +: 64] = 64'h0103;
        exp_o(0, 4'b0001, 32'h0000_0002, 4'b0000);
        exp_s(0, 2, 4'h0, 8'd0, 1'b0, 4'd0);
        repeat (4) nxt();

        for (int d = 0; d < 2; d++) begin
            for (int k = osz(d); k > 0; k--) begin
                n_vec++; n_err++;
                $display("FAIL dut%0d output expectation never matched (cyc %0d)", d, ofront(d).cyc);
                opop(d);
            end
            for (int k = ssz(d); k > 0; k--) begin
                n_vec++; n_err++;
                $display("FAIL dut%0d status expectation never checked (cyc %0d)", d, sfront(d).cyc);
                spop(d);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
